// File: rtl/checker_pkg.sv
// Shared types for the checker sequencing block: FSM state encoding and the
// configuration bundle latched at the start of a run.
package checker_pkg;

  localparam int DEF_STRIDE_SIZE = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_EMIT  = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  typedef struct packed {
    logic [DEF_STRIDE_SIZE:0] stride;
    logic [2:0]               filter_size;
    logic [2:0]               if_size;
  } cfg_t;

endpackage

// File: rtl/checker_drain_cnt.sv
// Down-counter that times the MAC pipeline drain; zero marks the final drain
// cycle, so a load value of N gives N+1 drain cycles.
module checker_drain_cnt #(
  parameter int LOAD_VAL = 1,
  localparam int CNT_W   = (LOAD_VAL < 1) ? 1 : $clog2(LOAD_VAL + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CNT_W'(LOAD_VAL);
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/checker_ctrl.sv
// Sequencing FSM for checker_datapath: holds run configuration, strobes the
// address-advance load, gates the MAC and hands finished partial sums downstream.
module checker_ctrl
  import checker_pkg::*;
#(
  parameter int STRIDE_SIZE = DEF_STRIDE_SIZE,
  parameter int MAC_LATENCY = 2,
  parameter int PSUM_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [STRIDE_SIZE:0]  stride_in,
  input  logic [2:0]            filter_size_in,
  input  logic [2:0]            if_size_in,
  input  logic                  can_count,
  input  logic                  can_mult,
  input  logic                  par_done,
  input  logic                  chk_done,
  input  logic                  psum_ready,
  output logic [STRIDE_SIZE:0]  stride,
  output logic [2:0]            filter_size,
  output logic [2:0]            if_size,
  output logic                  load,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic                  psum_valid,
  output logic [PSUM_CNT_W-1:0] psum_count,
  output logic                  busy,
  output logic                  done
);

  state_t state_q, state_d;
  cfg_t   cfg_q, cfg_in;
  logic   fin_q;
  logic   advance;
  logic   part_end;
  logic   drain_zero;

  assign cfg_in = '{stride:      (DEF_STRIDE_SIZE+1)'(stride_in),
                    filter_size: filter_size_in,
                    if_size:     if_size_in};

  // chk_done takes priority over advancing: the run is over, no further load.
  assign advance  = can_count && can_mult && !chk_done;
  assign part_end = (state_q == ST_RUN) && (par_done || chk_done);

  checker_drain_cnt #(
    .LOAD_VAL (MAC_LATENCY - 1)
  ) u_drain_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (part_end),
    .dec  (state_q == ST_DRAIN),
    .zero (drain_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every variable in a combinational block gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)      state_d = ST_INIT;
      ST_INIT:                  state_d = ST_RUN;
      ST_RUN:   if (part_end)   state_d = ST_DRAIN;
      ST_DRAIN: if (drain_zero) state_d = ST_EMIT;
      ST_EMIT:  if (psum_ready) state_d = fin_q ? ST_FIN : ST_RUN;
      ST_FIN:                   state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load       = 1'b0;
    mac_en     = 1'b0;
    mac_clr    = 1'b0;
    psum_valid = 1'b0;
    done       = 1'b0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_INIT: begin
        load    = 1'b1;
        mac_clr = 1'b1;
      end
      ST_RUN: begin
        load   = advance;
        mac_en = advance;
      end
      ST_EMIT: begin
        psum_valid = 1'b1;
        mac_clr    = psum_ready && !fin_q;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q      <= '0;
      fin_q      <= 1'b0;
      psum_count <= '0;
    end else begin
      if ((state_q == ST_IDLE) && start) begin
        cfg_q      <= cfg_in;
        fin_q      <= 1'b0;
        psum_count <= '0;
      end
      if ((state_q == ST_RUN) && chk_done) begin
        fin_q <= 1'b1;
      end
      if ((state_q == ST_EMIT) && psum_ready) begin
        psum_count <= psum_count + PSUM_CNT_W'(1);
      end
    end
  end

  assign stride      = (STRIDE_SIZE+1)'(cfg_q.stride);
  assign filter_size = cfg_q.filter_size;
  assign if_size     = cfg_q.if_size;

endmodule

// File: tb/tb_checker_ctrl.sv
// Self-checking bench for checker_ctrl: the bench plays the datapath, pushes an
// expected psum (due cycle, count) when it ends a partial, pops it on psum_valid.
module tb_checker_ctrl;
  import checker_pkg::*;

  localparam int STRIDE_SIZE = 2;
  localparam int MAC_LATENCY = 2;
  localparam int PSUM_CNT_W  = 2;
  localparam int CNT_MOD     = 1 << PSUM_CNT_W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic [STRIDE_SIZE:0]  stride_in = '0;
  logic [2:0]            filter_size_in = '0;
  logic [2:0]            if_size_in = '0;
  logic                  can_count = 1'b1;
  logic                  can_mult = 1'b1;
  logic                  par_done = 1'b0;
  logic                  chk_done = 1'b0;
  logic                  psum_ready = 1'b0;
  logic [STRIDE_SIZE:0]  stride;
  logic [2:0]            filter_size;
  logic [2:0]            if_size;
  logic                  load, mac_en, mac_clr, psum_valid, busy, done;
  logic [PSUM_CNT_W-1:0] psum_count;

  checker_ctrl #(
    .STRIDE_SIZE (STRIDE_SIZE),
    .MAC_LATENCY (MAC_LATENCY),
    .PSUM_CNT_W  (PSUM_CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stride_in      (stride_in),
    .filter_size_in (filter_size_in),
    .if_size_in     (if_size_in),
    .can_count      (can_count),
    .can_mult       (can_mult),
    .par_done       (par_done),
    .chk_done       (chk_done),
    .psum_ready     (psum_ready),
    .stride         (stride),
    .filter_size    (filter_size),
    .if_size        (if_size),
    .load           (load),
    .mac_en         (mac_en),
    .mac_clr        (mac_clr),
    .psum_valid     (psum_valid),
    .psum_count     (psum_count),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int count;
  } exp_t;

  exp_t sb[$];
  int   sb_count;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [2:0] exp_stride, exp_filter, exp_if;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_cfg(input string tag);
    check({tag, "_stride"}, 32'(stride), 32'(exp_stride));
    check({tag, "_filter"}, 32'(filter_size), 32'(exp_filter));
    check({tag, "_ifsize"}, 32'(if_size), 32'(exp_if));
  endtask

  // One complete run: n_psum partials of seg_len RUN cycles each; the last one
  // ends with chk_done (coincident with par_done, or alone when tail_chk).
  task automatic run_job(input int n_psum, input int seg_len, input bit tail_chk,
                         input int stall_len, input int bp_len, input bit poke_busy,
                         input logic [2:0] s, input logic [2:0] f, input logic [2:0] i);
    exp_t it;
    int   waited, run_cycles;
    bit   last, chk_only;
    @(negedge clk);
    stride_in = s; filter_size_in = f; if_size_in = i; start = 1'b1;
    #1 check("idle_busy", 32'(busy), 0);
    exp_stride = s; exp_filter = f; exp_if = i;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("init_load", 32'(load), 1);
    check("init_clr", 32'(mac_clr), 1);
    check("init_mac_en", 32'(mac_en), 0);
    check("init_busy", 32'(busy), 1);
    check("init_count", 32'(psum_count), 0);
    check_cfg("init");
    sb_count = 0;
    @(negedge clk);
    for (int p = 0; p < n_psum; p++) begin
      last       = (p == n_psum - 1);
      chk_only   = last && tail_chk;
      run_cycles = chk_only ? 1 : seg_len;
      for (int c = 0; c < run_cycles; c++) begin
        if (p == 0 && c == 1 && stall_len > 0) begin
          can_mult = 1'b0;
          for (int k = 0; k < stall_len; k++) begin
            #1;
            check("stall_load", 32'(load), 0);
            check("stall_mac_en", 32'(mac_en), 0);
            check("stall_busy", 32'(busy), 1);
            @(negedge clk);
          end
          can_mult = 1'b1;
        end
        if (poke_busy && p == 0 && c == 0) begin
          start = 1'b1;
          stride_in = ~s; filter_size_in = ~f; if_size_in = ~i;
        end else begin
          start = 1'b0;
        end
        par_done = (c == run_cycles - 1) && !chk_only;
        chk_done = (c == run_cycles - 1) && last;
        #1;
        check("run_load", 32'(load), 32'(!chk_done));
        check("run_mac_en", 32'(mac_en), 32'(!chk_done));
        check("run_clr", 32'(mac_clr), 0);
        check("run_valid", 32'(psum_valid), 0);
        check_cfg("run");
        if (c == run_cycles - 1) begin
          sb_count = (sb_count + 1) % CNT_MOD;
          it.due   = cyc + MAC_LATENCY + 1;
          it.count = sb_count;
          sb.push_back(it);
        end
        @(negedge clk);
      end
      start = 1'b0; par_done = 1'b0; chk_done = 1'b0;
      psum_ready = (bp_len == 0);
      waited = 0;
      #1;
      while (!psum_valid && waited < 16) begin
        check("drain_load", 32'(load), 0);
        check("drain_mac_en", 32'(mac_en), 0);
        @(negedge clk);
        #1;
        waited++;
      end
      if (!psum_valid) begin
        check("emit_timeout", 32'(psum_valid), 1);
        psum_ready = 1'b0;
        return;
      end
      it = sb.pop_front();
      check("emit_latency", 32'(cyc), 32'(it.due));
      for (int k = 0; k < bp_len; k++) begin
        check("bp_valid", 32'(psum_valid), 1);
        check("bp_count", 32'(psum_count), 32'((it.count + CNT_MOD - 1) % CNT_MOD));
        check("bp_clr", 32'(mac_clr), 0);
        @(negedge clk);
        #1;
      end
      psum_ready = 1'b1;
      #1;
      check("emit_valid", 32'(psum_valid), 1);
      check("emit_clr", 32'(mac_clr), 32'(!last));
      @(negedge clk);
      psum_ready = 1'b0;
      #1;
      check("hs_count", 32'(psum_count), 32'(it.count));
      check("hs_valid", 32'(psum_valid), 0);
    end
    check("fin_done", 32'(done), 1);
    check("fin_busy", 32'(busy), 1);
    check("sb_empty", 32'(sb.size()), 0);
    @(negedge clk);
    #1;
    check("post_done", 32'(done), 0);
    check("post_busy", 32'(busy), 0);
    check_cfg("hold");
  endtask

  task automatic reset_mid_emit();
    int waited;
    @(negedge clk);
    stride_in = 3'd2; filter_size_in = 3'd3; if_size_in = 3'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    par_done = 1'b1;
    @(negedge clk);
    par_done = 1'b0; psum_ready = 1'b0;
    waited = 0;
    #1;
    while (!psum_valid && waited < 16) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("rst_pre_valid", 32'(psum_valid), 1);
    #1 rst = 1'b0;
    #1;
    check("rst_valid", 32'(psum_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", 32'(psum_count), 0);
    check("rst_stride", 32'(stride), 0);
    check("rst_filter", 32'(filter_size), 0);
    check("rst_ifsize", 32'(if_size), 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check("rst_hold_done", 32'(done), 0);
      check("rst_hold_busy", 32'(busy), 0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", 32'(busy), 0);
    check("reset_load", 32'(load), 0);
    check("reset_valid", 32'(psum_valid), 0);
    check("reset_done", 32'(done), 0);
    check("reset_count", 32'(psum_count), 0);
    check("reset_stride", 32'(stride), 0);
    @(negedge clk);
    rst = 1'b1;

    // nominal: 3 psums, 9 loads including the INIT load, coincident finish
    run_job(3, 3, 1'b0, 0, 0, 1'b0, 3'd1, 3'd3, 3'd5);
    // stall on can_mult for 4 cycles, backpressure for 5 cycles
    run_job(2, 4, 1'b0, 4, 5, 1'b0, 3'd2, 3'd2, 3'd4);
    // single coincident par_done/chk_done, config change and start while busy
    run_job(1, 2, 1'b0, 0, 0, 1'b1, 3'd3, 3'd1, 3'd7);
    // 5 psums, last from chk_done alone, counter wraps to 1
    run_job(5, 2, 1'b1, 0, 2, 1'b1, 3'd4, 3'd5, 3'd3);
    reset_mid_emit();
    run_job(1, 1, 1'b0, 0, 0, 1'b0, 3'd5, 3'd6, 3'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
